// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the MMCM clock-domain sequencer.
package clkgen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

    // A programmed ratio of 0 is treated as divide-by-1.
    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: a CE strobe every max(div,1) active cycles plus a
// square wave that flips on each strobe.
module clk_en_div
    import clkgen_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic [DIV_W-1:0] div,
    output logic             ce,
    output logic             toggle
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] d_cur;
    logic             on;
    logic             wrap;

    // On the first active cycle div_act is still empty, so the live ratio is used.
    always_comb begin
        d_cur = DIV_W'(eff_div(32'(on ? div_act : div)));
        wrap  = (cnt == d_cur - DIV_W'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            cnt     <= '0;
            div_act <= '0;
            on      <= 1'b0;
            ce      <= 1'b0;
            toggle  <= 1'b0;
        end else begin
            on <= 1'b1;
            ce <= wrap;
            if (wrap) begin
                cnt     <= '0;
                toggle  <= ~toggle;
                div_act <= div;
            end else begin
                cnt <= cnt + DIV_W'(1);
                if (!on) begin
                    div_act <= div;
                end
            end
        end
    end

endmodule

// File: rtl/clkgen_seq.sv
// Lock qualification, downstream reset release, lock-loss tracking and the
// per-channel clock-enable generators, all on the single MMCM output clock.
module clkgen_seq
    import clkgen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int LOSS_W      = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    LOCKED,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    input  logic [NUM_CH-1:0]       CH_EN,
    input  logic                    CLR_LOST,
    output logic                    RST_OUT_N,
    output logic [NUM_CH-1:0]       CE,
    output logic [NUM_CH-1:0]       TOGGLE,
    output logic                    LOCK_LOST,
    output logic [LOSS_W-1:0]       LOSS_CNT
);

    localparam int ST_W = $clog2(LOCK_STABLE);

    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s;
    state_t                 state;
    logic [ST_W-1:0]        st_cnt;
    logic                   loss;
    logic                   run_ok;

    assign lock_s = sync[SYNC_STAGES-1];
    assign loss   = (state == RUN) && !lock_s;
    // Channels stop on the same edge that leaves RUN, not one cycle later.
    assign run_ok = (state == RUN) && lock_s;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], LOCKED};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= WAIT_LOCK;
            st_cnt    <= '0;
            RST_OUT_N <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state  <= STABLE;
                        st_cnt <= '0;
                    end
                end
                STABLE: begin
                    st_cnt <= st_cnt + ST_W'(1);
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (st_cnt == ST_W'(LOCK_STABLE - 1)) begin
                        state     <= RUN;
                        RST_OUT_N <= 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        RST_OUT_N <= 1'b0;
                    end
                end
                default: begin
                    state     <= WAIT_LOCK;
                    RST_OUT_N <= 1'b0;
                end
            endcase
        end
    end

    // A loss coinciding with a clear is still recorded, as the first new event.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            LOCK_LOST <= 1'b0;
            LOSS_CNT  <= '0;
        end else if (loss) begin
            LOCK_LOST <= 1'b1;
            if (CLR_LOST) begin
                LOSS_CNT <= LOSS_W'(1);
            end else if (!(&LOSS_CNT)) begin
                LOSS_CNT <= LOSS_CNT + LOSS_W'(1);
            end
        end else if (CLR_LOST) begin
            LOCK_LOST <= 1'b0;
            LOSS_CNT  <= '0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_en_div #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk    (CLK),
            .rst_n  (RST_N),
            .active (run_ok && CH_EN[i]),
            .div    (DIV[i*DIV_W +: DIV_W]),
            .ce     (CE[i]),
            .toggle (TOGGLE[i])
        );
    end

endmodule

// File: tb/tb_clkgen_seq.sv
// Directed bench for clkgen_seq: lock-up, dividers, ratio change, lock loss,
// STABLE glitch and loss-counter clear/saturation.
module tb_clkgen_seq;

    localparam int NUM_CH = 2;
    localparam int DIV_W  = 16;
    localparam int LS     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    locked;
    logic                    clr_lost;
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH-1:0]       ch_en;

    logic                    rst_out_n;
    logic [NUM_CH-1:0]       ce;
    logic [NUM_CH-1:0]       toggle;
    logic                    lock_lost;
    logic [7:0]              loss_cnt;

    logic                    b_rst_out_n;
    logic [NUM_CH-1:0]       b_ce;
    logic [NUM_CH-1:0]       b_toggle;
    logic                    b_lock_lost;
    logic [1:0]              b_loss_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  en;
        logic [15:0] div0;
        logic [1:0]  ce;
        logic [1:0]  tog;
    } vec_t;

    vec_t vecs[18];

    clkgen_seq #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_STABLE(LS), .LOSS_W(8)
    ) dut (
        .CLK(clk), .RST_N(rst_n), .LOCKED(locked), .DIV(div), .CH_EN(ch_en),
        .CLR_LOST(clr_lost), .RST_OUT_N(rst_out_n), .CE(ce), .TOGGLE(toggle),
        .LOCK_LOST(lock_lost), .LOSS_CNT(loss_cnt)
    );

    // Narrow loss counter, used only to observe saturation.
    clkgen_seq #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_STABLE(LS), .LOSS_W(2)
    ) dut_sat (
        .CLK(clk), .RST_N(rst_n), .LOCKED(locked), .DIV(div), .CH_EN(ch_en),
        .CLR_LOST(clr_lost), .RST_OUT_N(b_rst_out_n), .CE(b_ce), .TOGGLE(b_toggle),
        .LOCK_LOST(b_lock_lost), .LOSS_CNT(b_loss_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (!rst_out_n && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(rst_out_n), 32'd1);
    endtask

    // One sampled cycle of LOCKED low; returns after the edge that records it.
    task automatic lose();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ch0 DIV 3 with ch1 DIV 0 (divide-by-1), then ch0 re-enabled with 5 -> 2.
        vecs[0]  = '{2'b11, 16'd3, 2'b10, 2'b10};
        vecs[1]  = '{2'b11, 16'd3, 2'b10, 2'b00};
        vecs[2]  = '{2'b11, 16'd3, 2'b11, 2'b11};
        vecs[3]  = '{2'b11, 16'd3, 2'b10, 2'b01};
        vecs[4]  = '{2'b11, 16'd3, 2'b10, 2'b11};
        vecs[5]  = '{2'b11, 16'd3, 2'b11, 2'b00};
        vecs[6]  = '{2'b11, 16'd3, 2'b10, 2'b10};
        vecs[7]  = '{2'b11, 16'd3, 2'b10, 2'b00};
        vecs[8]  = '{2'b10, 16'd5, 2'b10, 2'b10};
        vecs[9]  = '{2'b11, 16'd5, 2'b10, 2'b00};
        vecs[10] = '{2'b11, 16'd2, 2'b10, 2'b10};
        vecs[11] = '{2'b11, 16'd2, 2'b10, 2'b00};
        vecs[12] = '{2'b11, 16'd2, 2'b10, 2'b10};
        vecs[13] = '{2'b11, 16'd2, 2'b11, 2'b01};
        vecs[14] = '{2'b11, 16'd2, 2'b10, 2'b11};
        vecs[15] = '{2'b11, 16'd2, 2'b11, 2'b00};
        vecs[16] = '{2'b11, 16'd2, 2'b10, 2'b10};
        vecs[17] = '{2'b11, 16'd2, 2'b11, 2'b01};

        rst_n    = 1'b0;
        locked   = 1'b0;
        clr_lost = 1'b0;
        div      = '0;
        ch_en    = '0;
        repeat (3) tick();
        check("reset_rst_out_n", 32'(rst_out_n), 32'd0);
        check("reset_ce",        32'(ce),        32'd0);
        check("reset_toggle",    32'(toggle),    32'd0);
        check("reset_lock_lost", 32'(lock_lost), 32'd0);
        check("reset_loss_cnt",  32'(loss_cnt),  32'd0);

        // Lock-up: RST_OUT_N rises after e(LS+2) = e6.
        rst_n = 1'b1;
        locked = 1'b1;
        div = {16'd0, 16'd3};
        ch_en = 2'b11;
        for (int k = 0; k <= LS + 2; k++) begin
            tick();
            check($sformatf("lockup_e%0d", k), 32'(rst_out_n), (k == LS + 2) ? 32'd1 : 32'd0);
        end

        for (int i = 0; i < 18; i++) begin
            ch_en = vecs[i].en;
            div[15:0] = vecs[i].div0;
            tick();
            check($sformatf("vec%0d_ce", i),  32'(ce),     32'(vecs[i].ce));
            check($sformatf("vec%0d_tog", i), 32'(toggle), 32'(vecs[i].tog));
        end

        // Lock loss in RUN: one low sample, outputs drop after e2.
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        check("loss_e1_still_run", 32'(rst_out_n), 32'd1);
        tick();
        check("loss_rst_out_n", 32'(rst_out_n), 32'd0);
        check("loss_ce",        32'(ce),        32'd0);
        check("loss_toggle",    32'(toggle),    32'd0);
        check("loss_lock_lost", 32'(lock_lost), 32'd1);
        check("loss_cnt",       32'(loss_cnt),  32'd1);
        for (int k = 3; k <= 7; k++) begin
            tick();
            check($sformatf("relock_e%0d", k), 32'(rst_out_n), (k == 7) ? 32'd1 : 32'd0);
        end

        // Reset mid-RUN clears everything and is not a loss.
        rst_n = 1'b0;
        tick();
        check("midreset_rst_out_n", 32'(rst_out_n), 32'd0);
        check("midreset_lock_lost", 32'(lock_lost), 32'd0);
        check("midreset_loss_cnt",  32'(loss_cnt),  32'd0);
        check("midreset_ce",        32'(ce),        32'd0);

        // Glitch seen by the FSM at st_cnt=2 restarts the window.
        rst_n = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            if (t == 4) locked = 1'b0;
            if (t == 5) locked = 1'b1;
            tick();
            check($sformatf("glitch_t%0d", t), 32'(rst_out_n), (t == 11) ? 32'd1 : 32'd0);
        end
        check("glitch_lock_lost", 32'(lock_lost), 32'd0);

        for (int i = 0; i < 5; i++) begin
            lose();
            check($sformatf("loss%0d_cnt", i), 32'(loss_cnt), 32'(i + 1));
            wait_run($sformatf("loss%0d_relock", i));
        end
        check("five_loss_lock_lost", 32'(lock_lost),  32'd1);
        check("sat_loss_cnt",        32'(b_loss_cnt), 32'd3);

        // Clear on the same edge as a loss: the loss wins.
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        check("collide_loss_cnt",  32'(loss_cnt),   32'd1);
        check("collide_lock_lost", 32'(lock_lost),  32'd1);
        check("collide_sat_cnt",   32'(b_loss_cnt), 32'd1);

        wait_run("clear_relock");
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        check("clear_lock_lost", 32'(lock_lost), 32'd0);
        check("clear_loss_cnt",  32'(loss_cnt),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clkgen_seq.md
# clkgen_seq

Parametrised clock-domain sequencer that sits directly behind the MMCM clock generator. It synchronises the MMCM `LOCKED` flag and qualifies it over a programmable stability window. It then releases a downstream synchronous reset and produces `NUM_CH` independent programmable clock-enable strobes and divided square waves. Lock loss is tracked and reported. Downstream logic stays on the single MMCM output clock and uses `CE`/`TOGGLE` instead of extra clock nets.

## Interface
Parameters:
- `NUM_CH`, 2: number of clock-enable channels (1..8).
- `DIV_W`, 16: width of each channel's divide ratio.
- `LOCK_STABLE`, 1024: cycles `LOCKED` must stay high before reset release (≥2).
- `LOSS_W`, 8: width of the lock-loss event counter.

Ports:
- `CLK` in 1: system clock (MMCM output).
- `RST_N` in 1: reset, synchronous, active-low.
- `LOCKED` in 1: MMCM lock flag, asynchronous to `CLK`.
- `DIV` in `NUM_CH*DIV_W`: per-channel divide ratio; channel i occupies bits `[i*DIV_W +: DIV_W]`.
- `CH_EN` in `NUM_CH`: per-channel enable.
- `CLR_LOST` in 1: clears `LOCK_LOST` and `LOSS_CNT`.
- `RST_OUT_N` out 1: qualified downstream reset, active-low.
- `CE` out `NUM_CH`: one-cycle enable strobes.
- `TOGGLE` out `NUM_CH`: square wave that flips on each `CE`.
- `LOCK_LOST` out 1: sticky flag, set on lock loss while in RUN.
- `LOSS_CNT` out `LOSS_W`: count of lock-loss events, saturating.

## Operation
- `LOCKED` passes through a 2-flop synchroniser to give `lock_s`.
- FSM states:
  - WAIT_LOCK (reset state): `lock_s=1` → STABLE, with `st_cnt` cleared to 0.
  - STABLE: `st_cnt` increments each cycle. `lock_s=0` → WAIT_LOCK. `st_cnt==LOCK_STABLE-1` → RUN.
  - RUN: `lock_s=0` → WAIT_LOCK. On this transition, `LOCK_LOST` is set and `LOSS_CNT` increments; it saturates at all-ones.
- `RST_OUT_N` is a register: 1 only while the state is RUN.
- Per channel:
  - `cnt` and `div_act` are held at 0 when not in RUN or when `CH_EN[i]=0`. `CE[i]` and `TOGGLE[i]` are also held 0 in that case.
  - The effective ratio is `d = max(div_act, 1)`. `DIV=0` behaves as divide-by-1.
  - `div_act` loads from `DIV` on the first enabled cycle and on every wrap. A mid-period `DIV` change takes effect only after the current period completes.
  - Each enabled cycle: `CE <= (cnt==d-1)`, `cnt <= (cnt==d-1) ? 0 : cnt+1`, and `TOGGLE` flips whenever `CE` is set. The `TOGGLE` period is `2*d`.
- `CLR_LOST` clears both `LOCK_LOST` and `LOSS_CNT`. If `CLR_LOST` and a loss event occur in the same cycle, the loss wins: `LOCK_LOST=1`, `LOSS_CNT=1`.
- All outputs reset to 0 on `RST_N=0`. The synchroniser flops and `st_cnt` also reset to 0. Reset asserted mid-RUN drops `RST_OUT_N` at the next edge and does not count as a lock loss.

## Timing
- Edge e0 is the first edge that samples `LOCKED=1`.
  - `lock_s` is 1 after e1.
  - The state is STABLE after e2.
  - The state is RUN and `RST_OUT_N=1` after edge e(`LOCK_STABLE`+2).
- Lock loss: e0 is the first edge that samples `LOCKED=0`. `RST_OUT_N`, `CE` and `TOGGLE` are low after e2; `LOCK_LOST` and `LOSS_CNT` update at the same edge.
- A `LOCKED` low glitch of 1 or more sampled cycles during STABLE restarts the full window.
- First `CE[i]` comes `d` cycles after the channel becomes active, i.e. after RUN entry with `CH_EN[i]` high. After that, `CE[i]` recurs every `d` cycles with no jitter. For `d=1`, `CE` is high continuously from 1 cycle after activation.
- There is no combinational path from any input to any output.

## Structure
- Package `clkgen_pkg`:
  - state enum {WAIT_LOCK, STABLE, RUN}.
  - `SYNC_STAGES=2`.
  - the helper for effective ratio, `max(div,1)`.
- Sub-module `clk_en_div`: one channel (`cnt`, `div_act`, `CE`, `TOGGLE`). It is instantiated `NUM_CH` times by generate loop.
- Top level: synchroniser, FSM, stability counter, loss tracking.

## Test plan
- Lock-up: `LOCK_STABLE=4`, assert `RST_N`, raise `LOCKED` before edge e0 → `RST_OUT_N` rises after e6 and stays 0 before.
- Divider: `DIV`={3,0}, `CH_EN=2'b11` → ch0 `CE` every 3rd cycle starting 3 cycles after RUN entry, `TOGGLE` period 6; ch1 `CE` stuck high, `TOGGLE` alternates each cycle.
- Mid-period ratio change: ch0 `DIV` changes 5→2 at `cnt=1` → current period still ends at 5 cycles, then `CE` every 2 cycles.
- Lock loss in RUN: drop `LOCKED` for 1 cycle → `RST_OUT_N`, `CE`, `TOGGLE` are 0 after the 2nd sampling edge; `LOCK_LOST=1`, `LOSS_CNT=1`; a fresh `LOCK_STABLE` window is required before `RST_OUT_N` rises again.
- Glitch in STABLE: `LOCKED` low for 1 cycle at `st_cnt=2` → window restarts; `LOCK_LOST` stays 0.
- Clear vs. loss collision: `CLR_LOST` pulsed on the same edge as a loss, with `LOSS_CNT=5` → `LOSS_CNT=1`, `LOCK_LOST=1`. With `LOSS_W=2`, 5 losses → `LOSS_CNT=3` (saturated).
